// File: rtl/ac97_cmd_seq.sv
// AC'97 command sequencer: plays the codec init table over slots 1/2, then
// carries one user register read or write at a time, with read matching/timeout.
module ac97_cmd_seq #(
   parameter int READ_TIMEOUT = 4
) (
   input  logic        ac97_bitclk,
   input  logic        ac97_rst,
   input  logic        ac97_strobe,
   input  logic        ac97_codec_ready,
   input  logic [19:0] ac97_in_slot1,
   input  logic [19:0] ac97_in_slot2,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [6:0]  cmd_addr,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        init_done,
   output logic [19:0] ac97_out_slot1,
   output logic        ac97_out_slot1_valid,
   output logic [19:0] ac97_out_slot2,
   output logic        ac97_out_slot2_valid
);

   localparam int CW = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT + 1);

   typedef enum logic [2:0] {
      WAIT_READY = 3'd0,
      INIT       = 3'd1,
      IDLE       = 3'd2,
      CMD        = 3'd3,
      RD_WAIT    = 3'd4
   } state_e;

   // Packs {slot1, slot1_valid, slot2, slot2_valid} for one command frame.
   function automatic logic [41:0] frame_bits(input logic wr, input logic [6:0] addr,
                                              input logic [15:0] data);
      logic [19:0] s2;
      if (wr) begin
         s2 = {data, 4'h0};
      end else begin
         s2 = 20'h00000;
      end
      return {~wr, addr, 12'h000, 1'b1, s2, wr};
   endfunction

   function automatic logic [6:0] init_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    init_addr = 7'h02;
         3'd1:    init_addr = 7'h04;
         3'd2:    init_addr = 7'h18;
         3'd3:    init_addr = 7'h1A;
         default: init_addr = 7'h00;
      endcase
   endfunction

   function automatic logic [15:0] init_data(input logic [2:0] idx);
      case (idx)
         3'd2:    init_data = 16'h0808;
         default: init_data = 16'h0000;
      endcase
   endfunction

   state_e         state_q, state_d;
   logic [2:0]     idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           hold_write_q, hold_write_d;
   logic [6:0]     hold_addr_q, hold_addr_d;
   logic [15:0]    hold_data_q, hold_data_d;
   logic           sent_q, sent_d;
   logic [19:0]    slot1_q, slot1_d, slot2_q, slot2_d;
   logic           slot1_vld_q, slot1_vld_d, slot2_vld_q, slot2_vld_d;
   logic           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [15:0]    rsp_data_q, rsp_data_d;
   logic           init_done_q, init_done_d;
   logic           cmd_ready_q;

   logic           handshake, addr_match, timeout_hit, ready_lost, read_pending;
   logic [CW-1:0]  cnt_inc;
   logic           unused_bits;

   assign handshake   = cmd_valid & cmd_ready_q;
   assign addr_match  = (ac97_in_slot1[18:12] == hold_addr_q);
   assign cnt_inc     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
   assign timeout_hit = (cnt_inc == CW'(READ_TIMEOUT));
   assign ready_lost  = ac97_strobe & ~ac97_codec_ready & (state_q != WAIT_READY);
   assign unused_bits = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

   // A read is pending once accepted and until its response pulse.
   always_comb begin
      case (state_q)
         IDLE:    read_pending = handshake & ~cmd_write;
         CMD:     read_pending = ~hold_write_q;
         RD_WAIT: read_pending = 1'b1;
         default: read_pending = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge ac97_bitclk) begin
      if (ac97_rst) begin
         state_q <= WAIT_READY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (ready_lost) begin
         state_d = WAIT_READY;
      end else if (ac97_strobe) begin
         case (state_q)
            WAIT_READY: state_d = ac97_codec_ready ? INIT : WAIT_READY;
            INIT:       state_d = (idx_q == 3'd4) ? IDLE : INIT;
            IDLE:       state_d = handshake ? CMD : IDLE;
            CMD: begin
               if (!sent_q) begin
                  state_d = CMD;
               end else if (hold_write_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = RD_WAIT;
               end
            end
            RD_WAIT:    state_d = (addr_match || timeout_hit) ? IDLE : RD_WAIT;
            default:    state_d = WAIT_READY;
         endcase
      end else if (handshake) begin
         state_d = CMD;
      end else begin
         state_d = state_q;
      end
   end

   // Output and datapath next values.
   always_comb begin
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      hold_write_d = hold_write_q;
      hold_addr_d  = hold_addr_q;
      hold_data_d  = hold_data_q;
      sent_d       = sent_q;
      {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} = {slot1_q, slot1_vld_q, slot2_q, slot2_vld_q};
      init_done_d  = init_done_q;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = 16'h0000;
      rsp_err_d    = 1'b0;
      if (ready_lost) begin
         {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} = 42'h0;
         init_done_d = 1'b0;
         sent_d      = 1'b0;
         if (read_pending) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 16'hFFFF;
         end else begin
            rsp_valid_d = 1'b0;
         end
      end else if (ac97_strobe) begin
         case (state_q)
            WAIT_READY: begin
               if (ac97_codec_ready) begin
                  idx_d = 3'd0;
               end else begin
                  idx_d = idx_q;
               end
            end
            INIT: begin
               if (idx_q == 3'd4) begin
                  {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} = 42'h0;
                  init_done_d = 1'b1;
               end else begin
                  {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} =
                     frame_bits(1'b1, init_addr(idx_q), init_data(idx_q));
                  idx_d = idx_q + 3'd1;
               end
            end
            IDLE: begin
               // Handshake on the strobe edge goes straight onto the link.
               if (handshake) begin
                  hold_write_d = cmd_write;
                  hold_addr_d  = cmd_addr;
                  hold_data_d  = cmd_data;
                  sent_d       = 1'b1;
                  {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} =
                     frame_bits(cmd_write, cmd_addr, cmd_data);
               end else begin
                  {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} = 42'h0;
               end
            end
            CMD: begin
               if (sent_q) begin
                  {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} = 42'h0;
                  sent_d = 1'b0;
                  cnt_d  = {CW{1'b0}};
               end else begin
                  {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} =
                     frame_bits(hold_write_q, hold_addr_q, hold_data_q);
                  sent_d = 1'b1;
               end
            end
            RD_WAIT: begin
               if (addr_match) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = ac97_in_slot2[19:4];
               end else if (timeout_hit) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = 16'hFFFF;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               {slot1_d, slot1_vld_d, slot2_d, slot2_vld_d} = 42'h0;
            end
         endcase
      end else if (handshake) begin
         hold_write_d = cmd_write;
         hold_addr_d  = cmd_addr;
         hold_data_d  = cmd_data;
         sent_d       = 1'b0;
      end else begin
         sent_d = sent_q;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge ac97_bitclk) begin
      if (ac97_rst) begin
         idx_q        <= 3'd0;
         cnt_q        <= {CW{1'b0}};
         hold_write_q <= 1'b0;
         hold_addr_q  <= 7'h00;
         hold_data_q  <= 16'h0000;
         sent_q       <= 1'b0;
         slot1_q      <= 20'h00000;
         slot1_vld_q  <= 1'b0;
         slot2_q      <= 20'h00000;
         slot2_vld_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 16'h0000;
         rsp_err_q    <= 1'b0;
         init_done_q  <= 1'b0;
         cmd_ready_q  <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         hold_write_q <= hold_write_d;
         hold_addr_q  <= hold_addr_d;
         hold_data_q  <= hold_data_d;
         sent_q       <= sent_d;
         slot1_q      <= slot1_d;
         slot1_vld_q  <= slot1_vld_d;
         slot2_q      <= slot2_d;
         slot2_vld_q  <= slot2_vld_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         init_done_q  <= init_done_d;
         cmd_ready_q  <= (state_d == IDLE);
      end
   end

   assign cmd_ready            = cmd_ready_q;
   assign rsp_valid            = rsp_valid_q;
   assign rsp_data             = rsp_data_q;
   assign rsp_err              = rsp_err_q;
   assign init_done            = init_done_q;
   assign ac97_out_slot1       = slot1_q;
   assign ac97_out_slot1_valid = slot1_vld_q;
   assign ac97_out_slot2       = slot2_q;
   assign ac97_out_slot2_valid = slot2_vld_q;

endmodule

// File: tb/tb_ac97_cmd_seq.sv
// Self-checking bench for ac97_cmd_seq: directed literal scenarios followed by
// randomized traffic, all outputs compared every cycle against a frame-level model.
module tb_ac97_cmd_seq;

   localparam int RT    = 4;
   localparam int FRAME = 16;

   logic        clk = 1'b0;
   logic        rst, strobe, codec_ready;
   logic [19:0] in_s1, in_s2;
   logic        cmd_valid, cmd_write;
   logic [6:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        cmd_ready, rsp_valid, rsp_err, init_done, s1v, s2v;
   logic [15:0] rsp_data;
   logic [19:0] s1, s2;

   always #5 clk = ~clk;

   ac97_cmd_seq #(.READ_TIMEOUT(RT)) dut (
      .ac97_bitclk(clk), .ac97_rst(rst), .ac97_strobe(strobe),
      .ac97_codec_ready(codec_ready), .ac97_in_slot1(in_s1), .ac97_in_slot2(in_s2),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .init_done(init_done),
      .ac97_out_slot1(s1), .ac97_out_slot1_valid(s1v),
      .ac97_out_slot2(s2), .ac97_out_slot2_valid(s2v)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic [6:0]  init_a [4] = '{7'h02, 7'h04, 7'h18, 7'h1A};
   logic [15:0] init_d [4] = '{16'h0000, 16'h0000, 16'h0808, 16'h0000};

   bit          live = 1'b0;
   bit          up, busy, c_wr;
   int          init_pos, stage, waited;
   logic [6:0]  c_addr;
   logic [15:0] c_data;
   logic [19:0] e_s1 = 20'h0, e_s2 = 20'h0;
   bit          e_v1, e_v2, e_rv, e_re, e_done, e_ready;
   logic [15:0] e_rd = 16'h0;

   task automatic put(input bit wr, input logic [6:0] a, input logic [15:0] d);
      e_s1 = {~wr, a, 12'h000};
      e_v1 = 1'b1;
      e_s2 = wr ? {d, 4'h0} : 20'h00000;
      e_v2 = wr;
   endtask

   task automatic blank();
      e_s1 = 20'h00000; e_v1 = 1'b0; e_s2 = 20'h00000; e_v2 = 1'b0;
   endtask

   task automatic fail_rsp();
      e_rv = 1'b1; e_re = 1'b1; e_rd = 16'hFFFF;
   endtask

   always @(posedge clk) begin : model
      bit hs;
      live = 1'b1;
      e_rv = 1'b0; e_re = 1'b0; e_rd = 16'h0000;
      hs = cmd_valid && e_ready;
      if (rst) begin
         up = 1'b0; busy = 1'b0; e_done = 1'b0; init_pos = 0; stage = 0; waited = 0;
         blank();
      end else if (strobe && up && !codec_ready) begin
         if ((busy && !c_wr) || (hs && !cmd_write)) fail_rsp();
         up = 1'b0; busy = 1'b0; e_done = 1'b0;
         blank();
      end else if (strobe) begin
         if (!up) begin
            if (codec_ready) begin up = 1'b1; init_pos = 0; end
         end else if (init_pos < 4) begin
            put(1'b1, init_a[init_pos], init_d[init_pos]);
            init_pos++;
         end else if (init_pos == 4) begin
            blank(); e_done = 1'b1; init_pos = 5;
         end else if (!busy) begin
            if (hs) begin
               busy = 1'b1; stage = 1; c_wr = cmd_write; c_addr = cmd_addr; c_data = cmd_data;
               put(c_wr, c_addr, c_data);
            end else begin
               blank();
            end
         end else if (stage == 0) begin
            put(c_wr, c_addr, c_data); stage = 1;
         end else if (stage == 1) begin
            blank();
            if (c_wr) busy = 1'b0;
            else begin stage = 2; waited = 0; end
         end else begin
            if (in_s1[18:12] == c_addr) begin
               e_rv = 1'b1; e_rd = in_s2[19:4]; busy = 1'b0;
            end else begin
               waited++;
               if (waited == RT) begin fail_rsp(); busy = 1'b0; end
            end
         end
      end else if (hs) begin
         busy = 1'b1; stage = 0; c_wr = cmd_write; c_addr = cmd_addr; c_data = cmd_data;
      end
      e_ready = up && (init_pos == 5) && !busy;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (live) begin
         chk("cmd_ready", cmd_ready, e_ready);
         chk("init_done", init_done, e_done);
         chk("slot1", s1, e_s1);
         chk("slot1_valid", s1v, e_v1);
         chk("slot2", s2, e_s2);
         chk("slot2_valid", s2v, e_v2);
         chk("rsp_valid", rsp_valid, e_rv);
         chk("rsp_data", rsp_data, e_rd);
         chk("rsp_err", rsp_err, e_re);
      end
   end

   // ---------------- stimulus ----------------
   int phase = 0;
   bit last_strobe = 1'b0;

   task automatic step();
      strobe = (phase == FRAME - 1);
      last_strobe = strobe;
      @(posedge clk);
      #1;
      phase = (phase + 1) % FRAME;
   endtask

   task automatic next_strobe();
      do step(); while (!last_strobe);
   endtask

   task automatic lit(input string n, input logic [31:0] act, input logic [31:0] mdl,
                      input logic [31:0] exp);
      chk(n, act, exp);
      chk({n, "_model"}, mdl, exp);
   endtask

   task automatic issue(input bit wr, input logic [6:0] a, input logic [15:0] d);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
      step();
      cmd_valid = 1'b0;
   endtask

   function automatic logic [6:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 7'h7C;
         1:       return 7'h2C;
         2:       return 7'h10;
         default: return 7'h26;
      endcase
   endfunction

   initial begin
      rst = 1'b1; strobe = 1'b0; codec_ready = 1'b0; in_s1 = 20'h0; in_s2 = 20'h0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 7'h0; cmd_data = 16'h0;
      repeat (3) step();
      lit("rst_cmd_ready", cmd_ready, e_ready, 0);
      lit("rst_init_done", init_done, e_done, 0);
      lit("rst_slot1_valid", s1v, e_v1, 0);
      lit("rst_rsp_valid", rsp_valid, e_rv, 0);

      // Init table after codec ready
      rst = 1'b0; codec_ready = 1'b1;
      next_strobe();
      lit("init_f1_valid", s1v, e_v1, 0);
      next_strobe();
      lit("init_e0_slot1", s1, e_s1, 32'h02000);
      lit("init_e0_slot2", s2, e_s2, 32'h00000);
      lit("init_e0_v1", s1v, e_v1, 1);
      lit("init_e0_v2", s2v, e_v2, 1);
      next_strobe();
      lit("init_e1_slot1", s1, e_s1, 32'h04000);
      next_strobe();
      lit("init_e2_slot1", s1, e_s1, 32'h18000);
      lit("init_e2_slot2", s2, e_s2, 32'h08080);
      next_strobe();
      lit("init_e3_slot1", s1, e_s1, 32'h1A000);
      lit("init_e3_slot2", s2, e_s2, 32'h00000);
      next_strobe();
      lit("init_done_set", init_done, e_done, 1);
      lit("init_cmd_ready", cmd_ready, e_ready, 1);
      lit("init_end_v1", s1v, e_v1, 0);

      // Mid-frame write
      step(); step();
      issue(1'b1, 7'h2C, 16'hBB80);
      lit("wr_busy", cmd_ready, e_ready, 0);
      next_strobe();
      lit("wr_slot1", s1, e_s1, 32'h2C000);
      lit("wr_slot2", s2, e_s2, 32'hBB800);
      lit("wr_v1", s1v, e_v1, 1);
      lit("wr_v2", s2v, e_v2, 1);
      next_strobe();
      lit("wr_after_v1", s1v, e_v1, 0);
      lit("wr_after_v2", s2v, e_v2, 0);

      // Read with matching response two frames later
      step();
      issue(1'b0, 7'h7C, 16'h0000);
      next_strobe();
      lit("rd_slot1", s1, e_s1, 32'hFC000);
      lit("rd_v1", s1v, e_v1, 1);
      lit("rd_v2", s2v, e_v2, 0);
      next_strobe();
      lit("rd_clear_v1", s1v, e_v1, 0);
      next_strobe();
      lit("rd_nomatch", rsp_valid, e_rv, 0);
      in_s1 = 20'h7C000; in_s2 = 20'h41440;
      next_strobe();
      lit("rd_rsp_valid", rsp_valid, e_rv, 1);
      lit("rd_rsp_data", rsp_data, e_rd, 32'h4144);
      lit("rd_rsp_err", rsp_err, e_re, 0);
      step();
      lit("rd_rsp_once", rsp_valid, e_rv, 0);
      in_s1 = 20'h0; in_s2 = 20'h0;

      // Read timeout
      issue(1'b0, 7'h10, 16'h0000);
      next_strobe();
      next_strobe();
      for (int i = 0; i < RT - 1; i++) begin
         next_strobe();
         lit("to_wait", rsp_valid, e_rv, 0);
      end
      next_strobe();
      lit("to_rsp_valid", rsp_valid, e_rv, 1);
      lit("to_rsp_err", rsp_err, e_re, 1);
      lit("to_rsp_data", rsp_data, e_rd, 32'hFFFF);
      lit("to_cmd_ready", cmd_ready, e_ready, 1);

      // Handshake in the strobe cycle
      while (phase != FRAME - 1) step();
      issue(1'b1, 7'h26, 16'h1234);
      lit("hs_strobe_slot1", s1, e_s1, 32'h26000);
      lit("hs_strobe_slot2", s2, e_s2, 32'h12340);
      lit("hs_strobe_v1", s1v, e_v1, 1);
      next_strobe();

      // Codec-ready loss during RD_WAIT
      step();
      issue(1'b0, 7'h7C, 16'h0000);
      next_strobe();
      next_strobe();
      codec_ready = 1'b0;
      next_strobe();
      lit("loss_rsp_valid", rsp_valid, e_rv, 1);
      lit("loss_rsp_err", rsp_err, e_re, 1);
      lit("loss_rsp_data", rsp_data, e_rd, 32'hFFFF);
      lit("loss_init_done", init_done, e_done, 0);
      codec_ready = 1'b1;
      next_strobe();
      next_strobe();
      lit("replay_e0_slot1", s1, e_s1, 32'h02000);

      // Reset during third init entry
      next_strobe();
      next_strobe();
      lit("pre_rst_e2", s1, e_s1, 32'h18000);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      lit("rst_mid_slot1", s1, e_s1, 0);
      lit("rst_mid_v2", s2v, e_v2, 0);
      lit("rst_mid_init_done", init_done, e_done, 0);
      next_strobe();
      next_strobe();
      lit("restart_e0_slot1", s1, e_s1, 32'h02000);
      repeat (4) next_strobe();
      lit("restart_done", init_done, e_done, 1);

      // Randomized traffic
      for (int n = 0; n < 32000; n++) begin
         if (phase == 0) begin
            codec_ready = ($urandom_range(0, 24) != 0);
            in_s1 = {1'($urandom), pick_addr(), 12'($urandom)};
            in_s2 = 20'($urandom);
         end
         rst       = ($urandom_range(0, 799) == 0);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_write = 1'($urandom);
         cmd_addr  = pick_addr();
         cmd_data  = 16'($urandom);
         step();
      end
      rst = 1'b0; cmd_valid = 1'b0;
      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
